// File: rtl/fifo_rptr_empty.sv
// Read-side pointer and empty-flag logic for an asynchronous FIFO (Gray-coded pointer crossing).
// Optional fill level / almost-empty outputs are built when FIFO_RD_LEVEL_EN is defined.
module fifo_rptr_empty #(
    parameter int ADDRSIZE  = 4,
    parameter int AE_THRESH = 2
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic                rinc,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    output logic                runderflow
`ifdef FIFO_RD_LEVEL_EN
    ,
    output logic [ADDRSIZE:0]   rlevel,
    output logic                ralmost_empty
`endif
);

    logic [ADDRSIZE:0] rbin_q;
    logic [ADDRSIZE:0] rbin_d;
    logic [ADDRSIZE:0] rptr_q;
    logic [ADDRSIZE:0] rptr_d;
    logic              rempty_q;
    logic              rempty_d;
    logic              runderflow_q;
    logic              runderflow_d;
    logic              rd_accept;

    // A read is accepted only against the registered empty flag, so a read
    // presented on the cycle the FIFO becomes non-empty is still refused.
    assign rd_accept    = rinc & ~rempty_q;
    assign rbin_d       = rbin_q + {{ADDRSIZE{1'b0}}, rd_accept};
    assign rptr_d       = (rbin_d >> 1) ^ rbin_d;
    assign rempty_d     = (rptr_d == rq2_wptr);
    assign runderflow_d = rinc & rempty_q;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin_q       <= '0;
            rptr_q       <= '0;
            rempty_q     <= 1'b1;
            runderflow_q <= 1'b0;
        end else begin
            rbin_q       <= rbin_d;
            rptr_q       <= rptr_d;
            rempty_q     <= rempty_d;
            runderflow_q <= runderflow_d;
        end
    end

    assign raddr      = rbin_q[ADDRSIZE-1:0];
    assign rptr       = rptr_q;
    assign rempty     = rempty_q;
    assign runderflow = runderflow_q;

`ifdef FIFO_RD_LEVEL_EN
    localparam logic [ADDRSIZE:0] AE_THRESH_W = (ADDRSIZE+1)'(AE_THRESH);

    logic [ADDRSIZE:0] wbin_s;
    logic [ADDRSIZE:0] rlevel_q;
    logic [ADDRSIZE:0] rlevel_d;
    logic              ralmost_empty_q;
    logic              ralmost_empty_d;

    // Gray-to-binary: each bit is the XOR of itself and all more-significant Gray bits.
    always_comb begin
        wbin_s           = '0;
        wbin_s[ADDRSIZE] = rq2_wptr[ADDRSIZE];
        for (int i = ADDRSIZE - 1; i >= 0; i--) begin
            wbin_s[i] = wbin_s[i+1] ^ rq2_wptr[i];
        end
    end

    assign rlevel_d        = wbin_s - rbin_d;
    assign ralmost_empty_d = (rlevel_d <= AE_THRESH_W);

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rlevel_q        <= '0;
            ralmost_empty_q <= 1'b1;
        end else begin
            rlevel_q        <= rlevel_d;
            ralmost_empty_q <= ralmost_empty_d;
        end
    end

    assign rlevel        = rlevel_q;
    assign ralmost_empty = ralmost_empty_q;
`endif

endmodule

// File: doc/fifo_rptr_empty.md
FIFO_RPTR_EMPTY -- requirements
Module: fifo_rptr_empty

Interface
REQ-001 Parameter ADDRSIZE, default 4, is the FIFO address width; depth is 2^ADDRSIZE entries.
REQ-002 Parameter AE_THRESH, default 2, is the almost-empty threshold in entries.
REQ-003 rclk  input  1  read-domain clock; all state updates on its rising edge.
REQ-004 rrst_n  input  1  read-domain reset, asynchronous, active-low.
REQ-005 rinc  input  1  read request from the FIFO consumer.
REQ-006 rq2_wptr  input  ADDRSIZE+1  Gray-coded write pointer, already two-flop synchronized into rclk.
REQ-007 raddr  output  ADDRSIZE  binary read address to the dual-port memory.
REQ-008 rptr  output  ADDRSIZE+1  registered Gray-coded read pointer, for synchronization into the write domain.
REQ-009 rempty  output  1  registered empty flag.
REQ-010 runderflow  output  1  registered one-cycle pulse; rinc was asserted while rempty=1.
REQ-011 rlevel  output  ADDRSIZE+1  registered fill level in entries; present only with FIFO_RD_LEVEL_EN.
REQ-012 ralmost_empty  output  1  registered almost-empty flag; present only with FIFO_RD_LEVEL_EN.

Function
REQ-013 rbin (ADDRSIZE+1 bits) is the internal binary read pointer; raddr = rbin[ADDRSIZE-1:0], combinational from the register.
REQ-014 rbinnext = rbin + (rinc & ~rempty); the pointer never advances while rempty=1.
REQ-015 rgraynext = (rbinnext >> 1) ^ rbinnext; rptr <= rgraynext and rbin <= rbinnext every cycle.
REQ-016 rempty <= (rgraynext == rq2_wptr); registered, so a read that empties the FIFO raises rempty on the same edge that advances rptr.
REQ-017 Deassertion of rempty occurs on the first rclk edge after rq2_wptr differs from rgraynext; no other added latency.
REQ-018 Wrap: rbin wraps modulo 2^(ADDRSIZE+1); the MSB of rbin toggles every 2^ADDRSIZE reads; raddr wraps modulo 2^ADDRSIZE.
REQ-019 Underflow: rinc=1 with rempty=1 -> rbin, rptr, raddr unchanged; runderflow=1 for exactly the following cycle; continuous rinc while empty gives continuous runderflow.
REQ-020 Simultaneous rinc and a change of rq2_wptr in one cycle: the read is accepted per REQ-014 using the registered rempty; rempty is then evaluated against the new rq2_wptr.
REQ-021 rq2_wptr is treated as an arbitrary Gray value each cycle; no assumption about the number of write increments between samples.

Reset
REQ-022 While rrst_n=0: rbin=0, rptr=0, raddr=0, rempty=1, runderflow=0, rlevel=0, ralmost_empty=1.
REQ-023 Reset assertion mid-operation takes effect immediately, without waiting for rclk; in-flight reads are discarded.
REQ-024 After deassertion, the first rclk edge evaluates rempty normally against rq2_wptr.

Configuration
REQ-025 Macro FIFO_RD_LEVEL_EN defined: rq2_wptr is Gray-to-binary converted to wbin_s; rlevel <= wbin_s - rbinnext (modulo 2^(ADDRSIZE+1)); ralmost_empty <= (wbin_s - rbinnext) <= AE_THRESH.
REQ-026 Macro FIFO_RD_LEVEL_EN undefined: rlevel and ralmost_empty ports, their registers and the Gray-to-binary logic are absent; all other behaviour is identical.

Verification (ADDRSIZE=4, AE_THRESH=2)
REQ-027 Reset: rrst_n=0 with rclk running -> rempty=1, rptr=5'b00000, raddr=0, runderflow=0.
REQ-028 rq2_wptr=gray(3)=5'b00010, then rinc=1 for 3 cycles -> rempty=0 after one edge; raddr 0,1,2; after the third read rempty=1 and rptr=5'b00010.
REQ-029 Underflow: FIFO empty, rinc=1 for 1 cycle -> runderflow=1 for one cycle; rptr and raddr unchanged.
REQ-030 Wrap: feed rq2_wptr ahead and perform 16 reads -> rptr=gray(16)=5'b11000, raddr=0; after 32 reads rptr=5'b00000.
REQ-031 With FIFO_RD_LEVEL_EN: rbin=0, rq2_wptr=gray(10)=5'b01111 -> rlevel=10, ralmost_empty=0; after 8 reads rlevel=2, ralmost_empty=1.
REQ-032 Assert rrst_n=0 mid-burst with rlevel=5 -> all outputs return to REQ-022 values before the next rclk edge.
